// File: rtl/rgb2gray_pkg.sv
// Shared widths, default BT.601-style Q0.8 luminance weights and the rounding
// helper for the rgb_to_gray pipeline.
package rgb2gray_pkg;

    localparam int unsigned PIX_W   = 12;
    localparam int unsigned GRAY_W  = 8;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned K_W     = 8;
    localparam int unsigned PROD_W  = PIX_W + K_W;
    localparam int unsigned SUM_W   = PROD_W + 1;

    localparam int unsigned KR    = 77;
    localparam int unsigned KG    = 150;
    localparam int unsigned KB    = 29;
    localparam int unsigned ROUND = 128;

    // sum[19:8] is the 12-bit luma; its top 8 bits are the gray output.
    function automatic logic [GRAY_W-1:0] sum_to_gray(input logic [SUM_W-1:0] sum);
        return sum[PROD_W-1 -: GRAY_W];
    endfunction

endpackage

// File: rtl/rgb2gray_mac.sv
// Weighted RGB multiply (stage 1) and sum-with-round to 8-bit gray (stage 2).
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int unsigned KR = rgb2gray_pkg::KR,
    parameter int unsigned KG = rgb2gray_pkg::KG,
    parameter int unsigned KB = rgb2gray_pkg::KB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  red,
    input  logic [PIX_W-1:0]  green,
    input  logic [PIX_W-1:0]  blue,
    input  logic              load,
    input  logic              accum,
    output logic [GRAY_W-1:0] gray
);

    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] pg;
    logic [PROD_W-1:0] pb;
    logic [SUM_W-1:0]  sum_c;

    // Products only advance on valid pixels so stale data never reaches stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr <= '0;
            pg <= '0;
            pb <= '0;
        end else if (load) begin
            pr <= PROD_W'(KR) * PROD_W'(red);
            pg <= PROD_W'(KG) * PROD_W'(green);
            pb <= PROD_W'(KB) * PROD_W'(blue);
        end
    end

    // Weights sum to 256, so the rounded total always fits below bit 20.
    assign sum_c = SUM_W'(pr) + SUM_W'(pg) + SUM_W'(pb) + SUM_W'(ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray <= '0;
        end else if (accum) begin
            gray <= sum_to_gray(sum_c);
        end
    end

endmodule

// File: rtl/rgb_to_gray.sv
// Two-stage RGB-to-luminance converter; carries pixel valid and X/Y
// coordinates alongside the result with matching latency.
module rgb_to_gray
    import rgb2gray_pkg::*;
#(
    parameter int unsigned KR = rgb2gray_pkg::KR,
    parameter int unsigned KG = rgb2gray_pkg::KG,
    parameter int unsigned KB = rgb2gray_pkg::KB
) (
    input  logic               iCLK,
    input  logic               iReset,
    input  logic [PIX_W-1:0]   iRed,
    input  logic [PIX_W-1:0]   iGreen,
    input  logic [PIX_W-1:0]   iBlue,
    input  logic               iDval,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    output logic [GRAY_W-1:0]  oGray,
    output logic               oDval,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont
);

    if (KR + KG + KB != 256) begin : g_bad_weights
        $fatal(1, "rgb_to_gray: KR+KG+KB must equal 256");
    end

    logic               v1;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;

    rgb2gray_mac #(
        .KR(KR),
        .KG(KG),
        .KB(KB)
    ) u_mac (
        .clk   (iCLK),
        .rst   (iReset),
        .red   (iRed),
        .green (iGreen),
        .blue  (iBlue),
        .load  (iDval),
        .accum (v1),
        .gray  (oGray)
    );

    // Valid/coordinate delay line kept in step with the MAC stages.
    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) begin
            v1      <= 1'b0;
            x1      <= '0;
            y1      <= '0;
            oDval   <= 1'b0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            v1    <= iDval;
            oDval <= v1;
            if (iDval) begin
                x1 <= iX_Cont;
                y1 <= iY_Cont;
            end
            if (v1) begin
                oX_Cont <= x1;
                oY_Cont <= y1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Self-checking bench for rgb_to_gray: vector table, streamed frame rows,
// valid gaps and reset corner cases against a queue-based scoreboard.
module tb_rgb_to_gray;

    logic        iCLK = 1'b0;
    logic        iReset;
    logic [11:0] iRed;
    logic [11:0] iGreen;
    logic [11:0] iBlue;
    logic        iDval;
    logic [15:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic [7:0]  oGray;
    logic        oDval;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;

    rgb_to_gray dut (
        .iCLK    (iCLK),
        .iReset  (iReset),
        .iRed    (iRed),
        .iGreen  (iGreen),
        .iBlue   (iBlue),
        .iDval   (iDval),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .oGray   (oGray),
        .oDval   (oDval),
        .oX_Cont (oX_Cont),
        .oY_Cont (oY_Cont)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [7:0]  gray;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    typedef struct {
        logic [11:0] r;
        logic [11:0] g;
        logic [11:0] b;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  gray;
    } vec_t;

    exp_t sb[$];
    exp_t last;
    exp_t e;
    logic dv_d1;
    logic dv_d2;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] golden(input logic [11:0] r, input logic [11:0] g,
                                          input logic [11:0] b);
        int unsigned s;
        s = 77 * r + 150 * g + 29 * b + 128;
        return 8'((s >> 8) >> 4);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        last  = '0;
        dv_d1 = 1'b0;
        dv_d2 = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gray"}, int'(oGray), 0);
        chk({tag, "_dval"}, int'(oDval), 0);
        chk({tag, "_x"}, int'(oX_Cont), 0);
        chk({tag, "_y"}, int'(oY_Cont), 0);
    endtask

    // Drive one pixel just after a falling edge, clock it, check at the next falling edge.
    task automatic cycle(input logic dv, input logic [11:0] r, input logic [11:0] g,
                         input logic [11:0] b, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] exp_gray);
        iDval   = dv;
        iRed    = r;
        iGreen  = g;
        iBlue   = b;
        iX_Cont = x;
        iY_Cont = y;
        if (dv) sb.push_back('{gray: exp_gray, x: x, y: y});
        @(posedge iCLK);
        dv_d2 = dv_d1;
        dv_d1 = dv;
        @(negedge iCLK);
        chk("dval", int'(oDval), int'(dv_d2));
        if (dv_d2) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got output with no expected entry (t=%0t)", $time);
            end else begin
                last = sb.pop_front();
            end
        end
        chk("gray", int'(oGray), int'(last.gray));
        chk("x", int'(oX_Cont), int'(last.x));
        chk("y", int'(oY_Cont), int'(last.y));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 12'($urandom), 12'($urandom), 12'($urandom),
                  16'($urandom), 16'($urandom), 8'h00);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{12'hFF0, 12'hFF0, 12'hFF0, 16'd5,  16'd7,  8'hFF};
        vecs[1] = '{12'hFF0, 12'h000, 12'h000, 16'd1,  16'd2,  8'd76};
        vecs[2] = '{12'h000, 12'hFF0, 12'h000, 16'd3,  16'd4,  8'd149};
        vecs[3] = '{12'h000, 12'h000, 12'hFF0, 16'd9,  16'd10, 8'd28};
        vecs[4] = '{12'h000, 12'h000, 12'h000, 16'd11, 16'd12, 8'd0};
        vecs[5] = '{12'hFFF, 12'hFFF, 12'hFFF, 16'hFFFF, 16'hFFFF, 8'hFF};
        vecs[6] = '{12'h800, 12'h400, 12'h200, 16'd799, 16'd479, 8'd79};
        vecs[7] = '{12'h000, 12'h000, 12'h000, 16'd0,  16'd0,  8'd0};

        iReset = 1'b1;
        iDval = 1'b0; iRed = '0; iGreen = '0; iBlue = '0; iX_Cont = '0; iY_Cont = '0;
        clear_model();

        // Reset hold with toggling inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            iDval = 1'($urandom); iRed = 12'($urandom); iGreen = 12'($urandom);
            iBlue = 12'($urandom); iX_Cont = 16'($urandom); iY_Cont = 16'($urandom);
            #1 check_zero("rst_hold");
        end
        @(negedge iCLK);
        iReset = 1'b0;
        iDval  = 1'b0;
        idle(2);

        // Table vectors back to back
        for (int i = 0; i < 8; i++)
            cycle(1'b1, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].x, vecs[i].y, vecs[i].gray);
        idle(2);

        // Valid gap: 1,0,0,0,1 with gray holding across the gap
        cycle(1'b1, 12'hFF0, 12'h000, 12'h000, 16'd20, 16'd21, 8'd76);
        idle(3);
        cycle(1'b1, 12'h000, 12'h000, 12'hFF0, 16'd22, 16'd23, 8'd28);
        idle(2);

        // Streamed frame rows, 8-bit image scaled to 12 bits
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 800; x++) begin
                logic [11:0] r, g, b;
                r = {8'($urandom), 4'b0};
                g = {8'($urandom), 4'b0};
                b = {8'($urandom), 4'b0};
                cycle(1'b1, r, g, b, 16'(x), 16'(y), golden(r, g, b));
            end
        end
        idle(2);

        // Mid-stream reset between two valid pixels
        cycle(1'b1, 12'h123, 12'h456, 12'h789, 16'd30, 16'd31, golden(12'h123, 12'h456, 12'h789));
        cycle(1'b1, 12'hABC, 12'hDEF, 12'h321, 16'd32, 16'd33, golden(12'hABC, 12'hDEF, 12'h321));
        iReset = 1'b1;
        #1 check_zero("rst_async");
        clear_model();
        iDval = 1'b1; iRed = 12'hFFF; iGreen = 12'hFFF; iBlue = 12'hFFF;
        @(negedge iCLK);
        check_zero("rst_mid");
        iReset = 1'b0;
        idle(3);
        cycle(1'b1, 12'h000, 12'hFF0, 12'h000, 16'd40, 16'd41, 8'd149);
        idle(2);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
